// File: rtl/bist_sequencer.sv
// Built-in self-test sequencer: clears the DUT, drives LFSR patterns, and compacts responses in a MISR.
// Optional macro BIST_SIG_OUT_EN adds a registered SIG port holding the final signature.
module bist_sequencer #(
    parameter int unsigned NPAT     = 1024,
    parameter int unsigned INIT_CYC = 2,
    parameter logic [15:0] SEED     = 16'hACE1,
    parameter logic [15:0] GOLDEN   = 16'h0000
) (
    input  logic        CK,
    input  logic        RN,
    input  logic        START,
    input  logic        ABORT,
    output logic [2:0]  TV,
    input  logic [5:0]  DUT_RESP,
    output logic        BUSY,
    output logic        DONE,
    output logic        PASS
`ifdef BIST_SIG_OUT_EN
    ,
    output logic [15:0] SIG
`endif
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        RUN   = 3'd2,
        FLUSH = 3'd3,
        CMP   = 3'd4
    } state_e;

    localparam logic [15:0] INIT_LAST = 16'(INIT_CYC - 1);
    localparam logic [15:0] RUN_LAST  = 16'(NPAT - 1);

    state_e      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [15:0] misr_q, misr_d;
    logic [15:0] cnt_q, cnt_d;
    logic        pass_q, pass_d;
    logic [2:0]  tv;
    logic        busy;
    logic        done;

    // Both registers share the x^16+x^14+x^13+x^11 tap set (bits 15,13,12,10).
    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic logic [15:0] misr_step(input logic [15:0] m, input logic [5:0] resp);
        return {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]} ^ {10'b0, resp};
    endfunction

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
        state_d = state_q;
        lfsr_d  = lfsr_q;
        misr_d  = misr_q;
        pass_d  = pass_q;
        tv      = 3'b000;
        busy    = 1'b1;
        done    = 1'b0;

        unique case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (START) begin
                    state_d = INIT;
                    lfsr_d  = SEED;
                    misr_d  = '0;
                    pass_d  = 1'b0;
                end
            end
            INIT: begin
                tv = 3'b001;
                if (cnt_q == INIT_LAST) state_d = RUN;
            end
            RUN: begin
                tv     = lfsr_q[2:0];
                lfsr_d = lfsr_step(lfsr_q);
                misr_d = misr_step(misr_q, DUT_RESP);
                if (cnt_q == RUN_LAST) state_d = FLUSH;
            end
            FLUSH: begin
                misr_d  = misr_step(misr_q, DUT_RESP);
                state_d = CMP;
            end
            CMP: begin
                done    = 1'b1;
                pass_d  = (misr_q == GOLDEN);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Abort overrides whatever the active state decided; the signature is frozen as-is.
        if (state_q != IDLE && ABORT) begin
            state_d = IDLE;
            lfsr_d  = lfsr_q;
            misr_d  = misr_q;
            pass_d  = 1'b0;
            done    = 1'b0;
        end

        if (state_d != state_q || state_q == IDLE) cnt_d = '0;
        else                                       cnt_d = cnt_q + 16'd1;
    end

    // NOTE: sequential state is written only with non-blocking assignments so all flops update together.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state_q <= IDLE;
            lfsr_q  <= SEED;
            misr_q  <= '0;
            cnt_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            misr_q  <= misr_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
        end
    end

    assign TV   = tv;
    assign BUSY = busy;
    assign DONE = done;
    assign PASS = pass_q;

`ifdef BIST_SIG_OUT_EN
    logic [15:0] sig_q, sig_d;

    always_comb begin
        sig_d = sig_q;
        if (state_q == CMP && !ABORT) sig_d = misr_q;
    end

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) sig_q <= '0;
        else     sig_q <= sig_d;
    end

    assign SIG = sig_q;
`endif

endmodule

// File: tb/tb_bist_sequencer.sv
// Directed bench for bist_sequencer: reset, pattern/TV sequence, PASS/FAIL signatures, abort, START handling.
// SIG checks are compiled in only when BIST_SIG_OUT_EN is defined.
module tb_bist_sequencer;

    logic CK = 1'b0;
    logic RN = 1'b1;
    logic START = 1'b0;
    logic ABORT = 1'b0;

    logic [5:0] resp_zero = 6'b000000;
    logic [5:0] resp_one  = 6'b000001;

    logic [2:0] tv0, tv1, tv2, tv3;
    logic busy0, busy1, busy2, busy3;
    logic done0, done1, done2, done3;
    logic pass0, pass1, pass2, pass3;
`ifdef BIST_SIG_OUT_EN
    logic [15:0] sig0, sig1, sig2, sig3;
`endif

    int total = 0;
    int bad   = 0;

    always #5 CK = ~CK;

    // u0/u1: NPAT=4, responses 0, golden 0 (match) and 1 (mismatch).
    bist_sequencer #(.NPAT(4), .INIT_CYC(2), .SEED(16'hACE1), .GOLDEN(16'h0000)) u0 (
        .CK(CK), .RN(RN), .START(START), .ABORT(ABORT), .TV(tv0), .DUT_RESP(resp_zero),
        .BUSY(busy0), .DONE(done0), .PASS(pass0)
`ifdef BIST_SIG_OUT_EN
        , .SIG(sig0)
`endif
    );
    bist_sequencer #(.NPAT(4), .INIT_CYC(2), .SEED(16'hACE1), .GOLDEN(16'h0001)) u1 (
        .CK(CK), .RN(RN), .START(START), .ABORT(ABORT), .TV(tv1), .DUT_RESP(resp_zero),
        .BUSY(busy1), .DONE(done1), .PASS(pass1)
`ifdef BIST_SIG_OUT_EN
        , .SIG(sig1)
`endif
    );
    // u2: NPAT=1, response 1 -> two MISR steps: 0x0001, 0x0003.
    bist_sequencer #(.NPAT(1), .INIT_CYC(2), .SEED(16'hACE1), .GOLDEN(16'h0003)) u2 (
        .CK(CK), .RN(RN), .START(START), .ABORT(ABORT), .TV(tv2), .DUT_RESP(resp_one),
        .BUSY(busy2), .DONE(done2), .PASS(pass2)
`ifdef BIST_SIG_OUT_EN
        , .SIG(sig2)
`endif
    );
    // u3: NPAT=14, response 1 -> 15 steps reach the feedback taps; hand-computed final 0x7FF2.
    bist_sequencer #(.NPAT(14), .INIT_CYC(2), .SEED(16'hACE1), .GOLDEN(16'h7FF2)) u3 (
        .CK(CK), .RN(RN), .START(START), .ABORT(ABORT), .TV(tv3), .DUT_RESP(resp_one),
        .BUSY(busy3), .DONE(done3), .PASS(pass3)
`ifdef BIST_SIG_OUT_EN
        , .SIG(sig3)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic wait_all_idle(input string tag);
        for (int i = 0; i < 60; i++) begin
            if (!busy0 && !busy3) break;
            tick();
        end
        check(tag, {busy0, busy3}, 2'b00);
    endtask

    logic [2:0] tv_exp [0:8];
    int busy_cnt;
    int done_cnt;
    int done_seen;

    initial begin
        // INIT 001 x2, RUN LFSR low bits ACE1/59C3/B387/670F, FLUSH/CMP/IDLE 000.
        tv_exp[0] = 3'b001; tv_exp[1] = 3'b001; tv_exp[2] = 3'b001; tv_exp[3] = 3'b011;
        tv_exp[4] = 3'b111; tv_exp[5] = 3'b111; tv_exp[6] = 3'b000; tv_exp[7] = 3'b000;
        tv_exp[8] = 3'b000;

        // Asynchronous reset with no clock edge in between.
        #1 RN = 1'b0;
        #1;
        check("rst_tv",   tv0,   3'b000);
        check("rst_busy", busy0, 1'b0);
        check("rst_done", done0, 1'b0);
        check("rst_pass", pass0, 1'b0);
        tick();
        tick();
        RN = 1'b1;
        tick();

        // Basic run: START pulsed for one cycle.
        START = 1'b1;
        tick();
        START = 1'b0;
        for (int i = 0; i < 9; i++) begin
            check($sformatf("run_busy%0d", i), busy0, (i < 8) ? 1'b1 : 1'b0);
            check($sformatf("run_tv%0d", i),   tv0,   tv_exp[i]);
            check($sformatf("run_done%0d", i), done0, (i == 7) ? 1'b1 : 1'b0);
            check($sformatf("u2_busy%0d", i),  busy2, (i < 5) ? 1'b1 : 1'b0);
            check($sformatf("u2_done%0d", i),  done2, (i == 4) ? 1'b1 : 1'b0);
            tick();
        end
        check("pass_golden0", pass0, 1'b1);
        check("pass_golden1", pass1, 1'b0);
        check("pass_npat1",   pass2, 1'b1);
        wait_all_idle("u3_finish");
        check("pass_npat14",  pass3, 1'b1);
`ifdef BIST_SIG_OUT_EN
        check("sig_u0", sig0, 16'h0000);
        check("sig_u2", sig2, 16'h0003);
        check("sig_u3", sig3, 16'h7FF2);
`endif

        // Abort in the third RUN cycle.
        START = 1'b1;
        tick();
        START = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 4; i++) begin
            done_seen += int'(done0);
            tick();
        end
        check("abort_tv_run3", tv0, 3'b111);
        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
        check("abort_busy", busy0, 1'b0);
        check("abort_pass", pass0, 1'b0);
        check("abort_u3_busy", busy3, 1'b0);
        for (int i = 0; i < 10; i++) begin
            done_seen += int'(done0);
            tick();
        end
        check("abort_no_done", done_seen, 0);
        check("abort_stay_idle", busy0, 1'b0);

        // START and ABORT together in IDLE: START wins.
        START = 1'b1;
        ABORT = 1'b1;
        tick();
        START = 1'b0;
        ABORT = 1'b0;
        check("start_abort_busy", busy0, 1'b1);
        busy_cnt = 1;
        done_cnt = int'(done0);
        for (int i = 0; i < 9; i++) begin
            tick();
            busy_cnt += int'(busy0);
            done_cnt += int'(done0);
        end
        check("start_abort_len",  busy_cnt, 8);
        check("start_abort_done", done_cnt, 1);
        check("start_abort_pass", pass0, 1'b1);
        wait_all_idle("idle_after_sa");

        // START held high: no restart while busy, restart one cycle after CMP.
        START = 1'b1;
        tick();
        busy_cnt = 0;
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            busy_cnt += int'(busy0);
            done_cnt += int'(done0);
            tick();
        end
        check("held_len",      busy_cnt, 8);
        check("held_done",     done_cnt, 1);
        check("held_idle_gap", busy0, 1'b0);
        tick();
        check("held_restart",  busy0, 1'b1);
        START = 1'b0;
        wait_all_idle("idle_after_held");
        check("held_pass", pass0, 1'b1);

        // Reset in the middle of RUN: immediate, no DONE, then a clean full test.
        START = 1'b1;
        tick();
        START = 1'b0;
        tick();
        tick();
        #2 RN = 1'b0;
        #1;
        check("midrst_busy", busy0, 1'b0);
        check("midrst_tv",   tv0,   3'b000);
        check("midrst_done", done0, 1'b0);
        check("midrst_pass", pass0, 1'b0);
        #3 RN = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            done_seen += int'(done0) + int'(busy0);
        end
        check("midrst_quiet", done_seen, 0);
        START = 1'b1;
        tick();
        START = 1'b0;
        busy_cnt = 0;
        done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            busy_cnt += int'(busy0);
            done_cnt += int'(done0);
            tick();
        end
        check("postrst_len",   busy_cnt, 8);
        check("postrst_done",  done_cnt, 1);
        check("postrst_pass0", pass0, 1'b1);
        check("postrst_pass1", pass1, 1'b0);
        wait_all_idle("idle_final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bist_sequencer.md
BIST_SEQUENCER -- requirements
Module: bist_sequencer

Interface
REQ-001 Parameters (name, default, meaning):
  NPAT 1024 (number of patterns applied, 1..65535)
  INIT_CYC 2 (DUT clear cycles, 1..15)
  SEED 16'hACE1 (LFSR start value, nonzero)
  GOLDEN 16'h0000 (expected final signature)
REQ-002 Ports (name, direction, width, meaning):
  CK input 1 (single clock, rising edge)
  RN input 1 (asynchronous active-low reset)
  START input 1 (begin a test; level sampled each cycle)
  ABORT input 1 (cancel the running test)
  TV output 3 (drives the DUT's three data inputs: TV[0]=clear input, TV[1], TV[2])
  DUT_RESP input 6 (the DUT's six registered outputs, concatenated)
  BUSY output 1 (test in progress)
  DONE output 1 (one-cycle completion pulse)
  PASS output 1 (final signature equals GOLDEN; held until the next START)
  SIG output 16 (final signature; present only under the macro in REQ-019)

Function
REQ-003 The FSM SHALL have states IDLE, INIT, RUN, FLUSH and CMP, all registered on CK.
REQ-004 IDLE -> INIT on START=1; START in any other state SHALL be ignored.
REQ-005 On the IDLE->INIT edge:
  LFSR := SEED
  MISR := 0
  PASS := 0
  cycle counter := 0
REQ-006 INIT SHALL last exactly INIT_CYC cycles with TV=3'b001, then go to RUN.
REQ-007 RUN SHALL last exactly NPAT cycles.
  TV = LFSR[2:0] each cycle.
  LFSR advances once per RUN cycle, then go to FLUSH.
REQ-008 LFSR step: fb = L[15]^L[13]^L[12]^L[10]; L := {L[14:0], fb}.
REQ-009 MISR step, in every RUN and FLUSH cycle only:
  fb = M[15]^M[13]^M[12]^M[10]
  M := {M[14:0], fb} ^ {10'b0, DUT_RESP}
REQ-010 FLUSH SHALL last one cycle (TV=3'b000), giving NPAT+1 MISR samples in total, then go to CMP.
REQ-011 CMP SHALL last one cycle.
  PASS := (MISR == GOLDEN).
  DONE is asserted during CMP.
  Next state is IDLE.
REQ-012 BUSY=1 in INIT, RUN, FLUSH and CMP; BUSY=0 in IDLE.
  Total BUSY length is INIT_CYC+NPAT+2 cycles.
REQ-013 TV=3'b000 in IDLE.
REQ-014 ABORT=1 in any BUSY state SHALL return to IDLE on the next edge.
  DONE stays 0.
  PASS = 0.
  MISR holds its value.
  ABORT takes priority over all other transitions.
REQ-015 Simultaneous START and ABORT in IDLE: START wins, because ABORT has no effect in IDLE.
REQ-016 The 16-bit cycle counter SHALL wrap nowhere.
  Terminal counts are INIT_CYC-1 and NPAT-1.
  The counter clears on every state change.

Reset
REQ-017 RN=0 SHALL asynchronously force:
  state=IDLE
  TV=0, BUSY=0, DONE=0, PASS=0
  LFSR=SEED, MISR=0, counter=0
REQ-018 Reset asserted mid-test SHALL abort without a DONE pulse.
  The first START after RN deasserts begins a full test.

Configuration
REQ-019 Macro BIST_SIG_OUT_EN.
  When defined: port SIG exists, is registered, and is loaded with the MISR value in CMP; reset value 0.
  When undefined: port SIG is absent and no other behaviour changes.

Verification
REQ-020 Reset: RN=0 at any point -> TV=0, BUSY=0, DONE=0, PASS=0 immediately, with no CK edge needed.
REQ-021 NPAT=4, INIT_CYC=2, START pulsed 1 cycle:
  BUSY high for exactly 8 cycles.
  TV sequence 001, 001, 001 (SEED low bits, 16'hACE1), 011 (16'h59C3), ...
  DONE single pulse in the 8th cycle.
REQ-022 DUT_RESP tied to 0, GOLDEN=16'h0000 -> PASS=1 after DONE; with GOLDEN=16'h0001 -> PASS=0.
REQ-023 ABORT=1 in the 3rd RUN cycle -> IDLE next edge, BUSY=0, DONE never pulses, PASS=0.
REQ-024 START held high throughout a test -> no restart while BUSY; a new test starts the cycle after CMP returns to IDLE.
REQ-025 With BIST_SIG_OUT_EN and DUT_RESP=6'b000001 constant, NPAT=1 -> SIG equals the 2-step MISR value computed by a reference model; PASS matches SIG==GOLDEN.
